rect_fill_engine: RTL and testbench
===================================

RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 Parameter FB_WIDTH, 160, framebuffer width in pixels.
REQ-002 Parameter FB_HEIGHT, 120, framebuffer height in lines.
REQ-003 vga_clk  in  1  pixel clock; all logic on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  engine can accept a command.
REQ-007 cmd_x0 / cmd_x1  in  9 each  inclusive left/right column.
REQ-008 cmd_y0 / cmd_y1  in  8 each  inclusive top/bottom line.
REQ-009 cmd_color  in  8  fill value (monochrome).
REQ-010 cmd_vb_wait  in  1  start filling only during vertical blank.
REQ-011 vblank  in  1  high while the display scan is outside the visible lines.
REQ-012 abort  in  1  synchronous cancel of the current command.
REQ-013 px_valid  out  1  pixel write offered.
REQ-014 px_ready  in  1  downstream accepts pixel.
REQ-015 px_x / px_y / px_data  out  9 / 8 / 8  pixel address and value, to framebuffer write port.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 done  out  1  one-cycle pulse at command completion.

Function
REQ-018 States: IDLE, WAIT_VB, FILL, DONE; cmd_ready = (state == IDLE).
REQ-019 Accept = cmd_valid && cmd_ready; all cmd_* fields captured into registers on the accept edge.
REQ-020 Clipping at accept: x1c = min(cmd_x1, FB_WIDTH-1), y1c = min(cmd_y1, FB_HEIGHT-1).
REQ-021 Command empty if cmd_x0 > x1c or cmd_y0 > y1c; no swapping; empty -> DONE directly, no pixels, vb_wait ignored.
REQ-022 Non-empty, cmd_vb_wait=0 -> FILL; cmd_vb_wait=1 -> WAIT_VB.
REQ-023 WAIT_VB -> FILL on the first cycle vblank is sampled high, including when vblank is already high on the cycle after accept.
REQ-024 FILL: raster order, x inner loop from x0 to x1c, then y+1; the first pixel is (x0, y0) with px_valid high in the first FILL cycle.
REQ-025 Latency: cmd_vb_wait=0 -> px_valid high on the cycle after accept.
REQ-026 Pixel advances only on px_valid && px_ready; px_x/px_y/px_data hold stable while px_valid && !px_ready.
REQ-027 Throughput: one pixel per cycle when px_ready stays high.
REQ-028 Handshake of pixel (x1c, y1c) -> DONE next cycle; px_valid low in DONE.
REQ-029 DONE lasts exactly one cycle with done=1, then IDLE; cmd_ready is high two cycles after the last pixel handshake.
REQ-030 abort=1 in WAIT_VB or FILL -> IDLE next cycle, px_valid low, no done pulse; abort is ignored in IDLE and DONE.
REQ-031 abort and a pixel handshake in the same cycle: the handshake counts, and the engine still goes to IDLE.
REQ-032 px_x/px_y/px_data are registered outputs, and px_valid is low outside FILL.
REQ-033 Counter compares use full 9/8-bit widths with no wrap; x1c = FB_WIDTH-1 causes no overflow.

Reset
REQ-034 rst_n low forces state IDLE, cmd_ready=1 after release, px_valid=0, busy=0, done=0, px_x/px_y/px_data=0, and clears all captured command registers.
REQ-035 Reset asserted mid-FILL aborts immediately; no done pulse and no further pixels after release.

Structure
REQ-036 Shared package vga_pkg holds FB_WIDTH/FB_HEIGHT defaults, coordinate width constants (9/8), the pixel width (8) and the fill_state_t enum.
REQ-037 No sub-module; clipping and empty check are combinational logic inside rect_fill_engine.

Verification
REQ-038 Rectangle (2,3)-(4,4), color 0x80, px_ready=1, vb_wait=0 -> 6 pixels in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), each 0x80; done pulses 1 cycle after (4,4); first pixel 1 cycle after accept.
REQ-039 Rectangle (150,110)-(300,200) -> clipped to (150,110)-(159,119); exactly 100 pixels; last pixel (159,119).
REQ-040 Command (10,5)-(9,5) with vb_wait=1 -> zero px_valid cycles; done 1 cycle after accept; cmd_ready high 2 cycles after accept.
REQ-041 Rectangle (0,0)-(1,0) with px_ready toggling 1,0,0,1 -> outputs stable during stalls; exactly 2 handshakes; no duplicate or skipped pixels.
REQ-042 vb_wait=1 with vblank low for 20 cycles, then high -> px_valid stays low for those 20 cycles and the first pixel appears on the cycle after vblank is sampled high.
REQ-043 Full-screen fill aborted at pixel 50, and separately reset asserted at pixel 50 -> in both cases px_valid drops next cycle, no done pulse, and a new command is accepted afterward.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and the rectangle-fill FSM state type.
// Coordinate widths cover the largest command values a caller may present.
package vga_pkg;

    localparam int unsigned FB_WIDTH_DEF  = 160;
    localparam int unsigned FB_HEIGHT_DEF = 120;

    localparam int unsigned X_W   = 9;
    localparam int unsigned Y_W   = 8;
    localparam int unsigned PIX_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWaitVb,
        StFill,
        StDone
    } fill_state_t;

endpackage

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips a command to the framebuffer and streams its pixels
// in raster order over a valid/ready write port, optionally deferring to vertical blank.
module rect_fill_engine
    import vga_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF
) (
    input  logic             vga_clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [X_W-1:0]   cmd_x0,
    input  logic [X_W-1:0]   cmd_x1,
    input  logic [Y_W-1:0]   cmd_y0,
    input  logic [Y_W-1:0]   cmd_y1,
    input  logic [PIX_W-1:0] cmd_color,
    input  logic             cmd_vb_wait,
    input  logic             vblank,
    input  logic             abort,

    output logic             px_valid,
    input  logic             px_ready,
    output logic [X_W-1:0]   px_x,
    output logic [Y_W-1:0]   px_y,
    output logic [PIX_W-1:0] px_data,

    output logic             busy,
    output logic             done
);

    localparam logic [X_W-1:0] XMax = X_W'(FB_WIDTH - 1);
    localparam logic [Y_W-1:0] YMax = Y_W'(FB_HEIGHT - 1);

    fill_state_t      state_q, state_d;
    logic [X_W-1:0]   x0_q, x0_d;
    logic [X_W-1:0]   x1_q, x1_d;
    logic [Y_W-1:0]   y1_q, y1_d;
    logic [X_W-1:0]   px_x_q, px_x_d;
    logic [Y_W-1:0]   px_y_q, px_y_d;
    logic [PIX_W-1:0] px_data_q, px_data_d;

    logic [X_W-1:0] x1c;
    logic [Y_W-1:0] y1c;
    logic           cmd_empty;
    logic           row_end;
    logic           rect_end;

    always_comb begin
        x1c       = (cmd_x1 > XMax) ? XMax : cmd_x1;
        y1c       = (cmd_y1 > YMax) ? YMax : cmd_y1;
        cmd_empty = (cmd_x0 > x1c) || (cmd_y0 > y1c);
        row_end   = (px_x_q == x1_q);
        rect_end  = row_end && (px_y_q == y1_q);
    end

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        px_x_d    = px_x_q;
        px_y_d    = px_y_q;
        px_data_d = px_data_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    // Start coordinates and colour live directly in the output registers.
                    x0_d      = cmd_x0;
                    x1_d      = x1c;
                    y1_d      = y1c;
                    px_x_d    = cmd_x0;
                    px_y_d    = cmd_y0;
                    px_data_d = cmd_color;
                    if (cmd_empty) begin
                        state_d = StDone;
                    end else if (cmd_vb_wait) begin
                        state_d = StWaitVb;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StWaitVb: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (vblank) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (px_ready) begin
                    if (rect_end) begin
                        state_d = StDone;
                    end else if (row_end) begin
                        px_x_d = x0_q;
                        px_y_d = px_y_q + Y_W'(1);
                    end else begin
                        px_x_d = px_x_q + X_W'(1);
                    end
                end
                // A handshake in the abort cycle still counts; abort wins the state.
                if (abort) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            x0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            px_x_q    <= '0;
            px_y_q    <= '0;
            px_data_q <= '0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            px_x_q    <= px_x_d;
            px_y_q    <= px_y_d;
            px_data_q <= px_data_d;
        end
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        px_valid  = (state_q == StFill);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        px_x      = px_x_q;
        px_y      = px_y_q;
        px_data   = px_data_q;
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: a table of rectangles with hand-computed clipping
// and pixel counts, plus sequences for vblank wait, stalls, abort and mid-fill reset.
module tb_rect_fill_engine;
    import vga_pkg::*;

    logic             vga_clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [X_W-1:0]   cmd_x0, cmd_x1;
    logic [Y_W-1:0]   cmd_y0, cmd_y1;
    logic [PIX_W-1:0] cmd_color;
    logic             cmd_vb_wait;
    logic             vblank;
    logic             abort;
    logic             px_valid;
    logic             px_ready;
    logic [X_W-1:0]   px_x;
    logic [Y_W-1:0]   px_y;
    logic [PIX_W-1:0] px_data;
    logic             busy;
    logic             done;

    int vec_count = 0;
    int err_count = 0;

    rect_fill_engine #(
        .FB_WIDTH  (160),
        .FB_HEIGHT (120)
    ) dut (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_x1      (cmd_x1),
        .cmd_y0      (cmd_y0),
        .cmd_y1      (cmd_y1),
        .cmd_color   (cmd_color),
        .cmd_vb_wait (cmd_vb_wait),
        .vblank      (vblank),
        .abort       (abort),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_data     (px_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [8:0] x0;
        logic [8:0] x1;
        logic [7:0] y0;
        logic [7:0] y1;
        logic [7:0] color;
        logic       vb_wait;
        logic [7:0] ready_pat;
        logic [8:0] exp_x1;
        logic [7:0] exp_y1;
        int         exp_count;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] x1,
                        input logic [7:0] y1, input logic [7:0] color, input logic vb);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_x0      = x0;
        cmd_x1      = x1;
        cmd_y0      = y0;
        cmd_y1      = y1;
        cmd_color   = color;
        cmd_vb_wait = vb;
        cmd_valid   = 1'b1;
        step();
        // Scramble the command bus so only the captured copy can be used.
        cmd_valid   = 1'b0;
        cmd_x0      = 9'h1ff;
        cmd_x1      = 9'h000;
        cmd_y0      = 8'hff;
        cmd_y1      = 8'h00;
        cmd_color   = 8'h5a;
        cmd_vb_wait = 1'b0;
    endtask

    // Expects to be called on the first FILL cycle.
    task automatic drain(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] x1,
                         input logic [7:0] y1, input logic [7:0] color, input logic [7:0] pat,
                         input int count);
        logic [8:0] ex;
        logic [7:0] ey;
        int n;
        int cyc;
        ex  = x0;
        ey  = y0;
        n   = 0;
        cyc = 0;
        check("first_px_valid", px_valid, 1);
        while (n < count && cyc < 40000) begin
            px_ready = pat[cyc % 8];
            if (!px_valid) begin
                check("px_valid_in_fill", px_valid, 1);
                break;
            end
            check("pixel", {7'd0, px_x, px_y, px_data}, {7'd0, ex, ey, color});
            if (px_ready) begin
                n++;
                if (ex == x1) begin
                    ex = x0;
                    ey = ey + 8'd1;
                end else begin
                    ex = ex + 9'd1;
                end
            end
            step();
            cyc++;
        end
        check("handshake_count", n, count);
        check("done_after_last", done, 1);
        check("px_valid_in_done", px_valid, 0);
        px_ready = 1'b1;
        step();
        check("done_one_cycle", done, 0);
        check("cmd_ready_after_done", cmd_ready, 1);
    endtask

    task automatic run_cmd(input vec_t v);
        px_ready = 1'b1;
        send(v.x0, v.y0, v.x1, v.y1, v.color, v.vb_wait);
        if (v.exp_count == 0) begin
            check("empty_done", done, 1);
            check("empty_px_valid", px_valid, 0);
            step();
            check("empty_done_clear", done, 0);
            check("empty_cmd_ready", cmd_ready, 1);
            check("empty_px_valid2", px_valid, 0);
        end else begin
            drain(v.x0, v.y0, v.exp_x1, v.exp_y1, v.color, v.ready_pat, v.exp_count);
        end
    endtask

    task automatic fill_to_50(input logic [7:0] color);
        px_ready = 1'b1;
        send(9'd0, 8'd0, 9'd511, 8'd255, color, 1'b0);
        for (int i = 0; i < 50; i++) begin
            check("full_pixel", {7'd0, px_x, px_y, px_data}, {7'd0, 9'(i), 8'd0, color});
            step();
        end
        check("pixel_50", {7'd0, px_x, px_y, px_data}, {7'd0, 9'd50, 8'd0, color});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //         x0      x1      y0      y1      color  vb    pat    ex1     ey1     count
        vecs[0] = '{9'd2,   9'd4,   8'd3,   8'd4,   8'h80, 1'b0, 8'hff, 9'd4,   8'd4,   6};
        vecs[1] = '{9'd150, 9'd300, 8'd110, 8'd200, 8'h3c, 1'b0, 8'hff, 9'd159, 8'd119, 100};
        vecs[2] = '{9'd10,  9'd9,   8'd5,   8'd5,   8'h11, 1'b1, 8'hff, 9'd9,   8'd5,   0};
        vecs[3] = '{9'd0,   9'd1,   8'd0,   8'd0,   8'ha5, 1'b0, 8'hf9, 9'd1,   8'd0,   2};
        vecs[4] = '{9'd159, 9'd159, 8'd119, 8'd119, 8'hff, 1'b0, 8'hff, 9'd159, 8'd119, 1};
        vecs[5] = '{9'd0,   9'd511, 8'd0,   8'd0,   8'h22, 1'b0, 8'hff, 9'd159, 8'd0,   160};
        vecs[6] = '{9'd5,   9'd6,   8'd118, 8'd255, 8'h33, 1'b0, 8'hf5, 9'd6,   8'd119, 4};
        vecs[7] = '{9'd200, 9'd300, 8'd0,   8'd0,   8'h44, 1'b1, 8'hff, 9'd159, 8'd0,   0};
        vecs[8] = '{9'd3,   9'd3,   8'd10,  8'd9,   8'h55, 1'b0, 8'hff, 9'd3,   8'd9,   0};

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_x0      = '0;
        cmd_x1      = '0;
        cmd_y0      = '0;
        cmd_y1      = '0;
        cmd_color   = '0;
        cmd_vb_wait = 1'b0;
        vblank      = 1'b0;
        abort       = 1'b0;
        px_ready    = 1'b0;
        step();
        step();
        check("rst_px_valid", px_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_outputs", {7'd0, px_x, px_y, px_data}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i]);
        end

        // Wait for vblank: 20 cycles low, then high.
        send(9'd3, 8'd3, 9'd4, 8'd3, 8'h66, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("vb_wait_px_valid", px_valid, 0);
            check("vb_wait_busy", busy, 1);
            step();
        end
        vblank = 1'b1;
        check("vb_wait_last_low", px_valid, 0);
        step();
        vblank = 1'b0;
        drain(9'd3, 8'd3, 9'd4, 8'd3, 8'h66, 8'hff, 2);

        // vblank already high on the cycle after accept.
        vblank = 1'b1;
        send(9'd7, 8'd1, 9'd7, 8'd1, 8'h77, 1'b1);
        check("vb_hi_wait_cycle", px_valid, 0);
        step();
        vblank = 1'b0;
        drain(9'd7, 8'd1, 9'd7, 8'd1, 8'h77, 8'hff, 1);

        // Abort while waiting for vblank wins over vblank.
        send(9'd1, 8'd1, 9'd2, 8'd2, 8'h12, 1'b1);
        abort  = 1'b1;
        vblank = 1'b1;
        step();
        abort  = 1'b0;
        vblank = 1'b0;
        check("abort_wait_px_valid", px_valid, 0);
        check("abort_wait_busy", busy, 0);
        check("abort_wait_done", done, 0);

        // Abort is ignored in IDLE: command offered with abort high is accepted.
        abort = 1'b1;
        px_ready = 1'b1;
        send(9'd8, 8'd8, 9'd9, 8'd8, 8'h9c, 1'b0);
        abort = 1'b0;
        drain(9'd8, 8'd8, 9'd9, 8'd8, 8'h9c, 8'hff, 2);

        // Full-screen fill aborted at pixel 50.
        fill_to_50(8'hc3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_px_valid", px_valid, 0);
        check("abort_done", done, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        step();
        check("abort_no_late_done", done, 0);
        run_cmd(vecs[0]);

        // Full-screen fill with reset asserted at pixel 50.
        fill_to_50(8'h3c);
        rst_n = 1'b0;
        #1;
        check("rst_mid_px_valid", px_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_outputs", {7'd0, px_x, px_y, px_data}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_rel_px_valid", px_valid, 0);
        check("rst_rel_done", done, 0);
        check("rst_rel_cmd_ready", cmd_ready, 1);
        run_cmd(vecs[3]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
